// File: rtl/regfile_2r1w_sb.sv
// Two-read / one-write register file with r0 hardwired to zero and a per-register
// scoreboard of pending writebacks. Reset or clr_req runs a one-entry-per-cycle
// clearing sweep, so the storage needs no parallel reset.
// Optional: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_2r1w_sb #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    input  logic             we,
    input  logic [AW-1:0]    w_adr,
    input  logic [WIDTH-1:0] w_data,
    input  logic [AW-1:0]    ra_adr,
    input  logic [AW-1:0]    rb_adr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_adr,
    output logic             pend_a,
    output logic             pend_b,
    output logic             busy
);

    typedef enum logic {StClear, StReady} state_e;

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    state_e                 state_q;
    logic [AW-1:0]          clr_idx_q;
    logic [DEPTH-1:0]       pend_q;
    logic [DEPTH-1:0]       pend_d;
    logic [WIDTH-1:0]       mem [DEPTH];

    logic                   mem_we;
    logic [AW-1:0]          mem_wa;
    logic [WIDTH-1:0]       mem_wd;
    logic                   ready;

    assign ready = (state_q == StReady);
    assign busy  = (state_q == StClear);

    // Control FSM: sweep sequencing and scoreboard update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            pend_q    <= '0;
        end else begin
            case (state_q)
                StClear: begin
                    if (clr_req) begin
                        clr_idx_q <= '0;
                    end else begin
                        clr_idx_q <= clr_idx_q + AW'(1);
                        if (clr_idx_q == LastIdx) state_q <= StReady;
                    end
                end
                StReady: begin
                    if (clr_req) begin
                        state_q   <= StClear;
                        clr_idx_q <= '0;
                        pend_q    <= '0;
                    end else begin
                        pend_q <= pend_d;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

    // Scoreboard next state: issue sets, writeback clears, set applied last so it wins.
    always_comb begin
        pend_d = pend_q;
        if (we) pend_d[w_adr] = 1'b0;
        if (iss_valid) pend_d[iss_adr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // Single write port shared by the clearing sweep and architectural writes.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = w_adr;
        mem_wd = w_data;
        if (!rst) begin
            if (busy) begin
                mem_we = 1'b1;
                mem_wa = clr_idx_q;
                mem_wd = '0;
            end else if (!clr_req && we && (w_adr != '0)) begin
                mem_we = 1'b1;
            end
        end
    end

    // Storage array, deliberately without reset so it maps to distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    logic hit_a;
    logic hit_b;
    logic iss_a;
    logic iss_b;

    // Read ports with forwarding of the write in flight this cycle.
    always_comb begin
        wr_live = ready && we && (w_adr != '0);
        hit_a   = wr_live && (ra_adr == w_adr);
        hit_b   = wr_live && (rb_adr == w_adr);
        iss_a   = iss_valid && (iss_adr == ra_adr);
        iss_b   = iss_valid && (iss_adr == rb_adr);
        ra_data = '0;
        rb_data = '0;
        pend_a  = 1'b0;
        pend_b  = 1'b0;
        if (!busy) begin
            if (ra_adr != '0) ra_data = hit_a ? w_data : mem[ra_adr];
            if (rb_adr != '0) rb_data = hit_b ? w_data : mem[rb_adr];
            // A same-cycle issue to the register keeps it pending.
            pend_a = pend_q[ra_adr] && !(hit_a && !iss_a);
            pend_b = pend_q[rb_adr] && !(hit_b && !iss_b);
        end
    end
`else
    // Read ports return registered contents only.
    always_comb begin
        ra_data = '0;
        rb_data = '0;
        pend_a  = 1'b0;
        pend_b  = 1'b0;
        if (!busy) begin
            if (ra_adr != '0) ra_data = mem[ra_adr];
            if (rb_adr != '0) rb_data = mem[rb_adr];
            pend_a = pend_q[ra_adr];
            pend_b = pend_q[rb_adr];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench for regfile_2r1w_sb (WIDTH=32, DEPTH=32).
module tb_regfile_2r1w_sb;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_req;
    logic             we;
    logic [AW-1:0]    w_adr;
    logic [WIDTH-1:0] w_data;
    logic [AW-1:0]    ra_adr;
    logic [AW-1:0]    rb_adr;
    logic [WIDTH-1:0] ra_data;
    logic [WIDTH-1:0] rb_data;
    logic             iss_valid;
    logic [AW-1:0]    iss_adr;
    logic             pend_a;
    logic             pend_b;
    logic             busy;

    int total = 0;
    int bad   = 0;

    regfile_2r1w_sb #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .we       (we),
        .w_adr    (w_adr),
        .w_data   (w_data),
        .ra_adr   (ra_adr),
        .rb_adr   (rb_adr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .iss_valid(iss_valid),
        .iss_adr  (iss_adr),
        .pend_a   (pend_a),
        .pend_b   (pend_b),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count consecutive busy samples, one per cycle, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL reset_busy got=%b want=1", busy);
        end
        rst = 1'b0;
        ra_adr = 5'd3;
        #1;
        total++;
        if (ra_data !== '0) begin
            bad++; $display("FAIL busy_read_zero got=%h want=0", ra_data);
        end
        count_busy(n);
        total++;
        if (n != 32) begin
            bad++; $display("FAIL sweep_len got=%0d want=32", n);
        end
        for (int i = 0; i < DEPTH; i++) begin
            ra_adr = AW'(i);
            rb_adr = AW'(DEPTH - 1 - i);
            #1;
            total++;
            if (ra_data !== '0 || rb_data !== '0 || pend_a !== 1'b0 || pend_b !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_zero adr=%0d got=%h/%h/%b/%b want=0", i,
                         ra_data, rb_data, pend_a, pend_b);
            end
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; w_adr = 5'd5; w_data = 32'hDEADBEEF;
        tick();
        w_adr = 5'd6; w_data = 32'h00000066;
        tick();
        we = 1'b0;
        ra_adr = 5'd5; rb_adr = 5'd5;
        #1;
        total++;
        if (ra_data !== 32'hDEADBEEF || rb_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_same got=%h/%h want=deadbeef", ra_data, rb_data);
        end
        rb_adr = 5'd6;
        #1;
        total++;
        if (ra_data !== 32'hDEADBEEF || rb_data !== 32'h00000066) begin
            bad++; $display("FAIL rd_diff got=%h/%h want=deadbeef/00000066", ra_data, rb_data);
        end
        we = 1'b1; w_adr = 5'd0; w_data = 32'h00001234;
        tick();
        we = 1'b0;
        ra_adr = 5'd0; rb_adr = 5'd0;
        #1;
        total++;
        if (ra_data !== '0 || rb_data !== '0) begin
            bad++; $display("FAIL r0_zero got=%h/%h want=0", ra_data, rb_data);
        end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_adr = 5'd7;
        ra_adr = 5'd7; rb_adr = 5'd8;
        #1;
        total++;
        if (pend_a !== 1'b0) begin
            bad++; $display("FAIL pend_before_edge got=%b want=0", pend_a);
        end
        tick();
        iss_valid = 1'b0;
        #1;
        total++;
        if (pend_a !== 1'b1 || pend_b !== 1'b0) begin
            bad++; $display("FAIL pend_set got=%b/%b want=1/0", pend_a, pend_b);
        end
        rb_adr = 5'd7;
        #1;
        total++;
        if (pend_b !== 1'b1) begin
            bad++; $display("FAIL pend_b_set got=%b want=1", pend_b);
        end
        we = 1'b1; w_adr = 5'd7; w_data = 32'h77;
        tick();
        we = 1'b0;
        #1;
        total++;
        if (pend_a !== 1'b0 || ra_data !== 32'h77) begin
            bad++; $display("FAIL pend_clear got=%b/%h want=0/00000077", pend_a, ra_data);
        end
        iss_valid = 1'b1; iss_adr = 5'd0;
        tick();
        iss_valid = 1'b0;
        ra_adr = 5'd0;
        #1;
        total++;
        if (pend_a !== 1'b0) begin
            bad++; $display("FAIL pend_r0 got=%b want=0", pend_a);
        end
    endtask

    task automatic test_set_wins();
        iss_valid = 1'b1; iss_adr = 5'd9;
        tick();
        we = 1'b1; w_adr = 5'd9; w_data = 32'h00000099;
        tick();
        iss_valid = 1'b0; we = 1'b0;
        ra_adr = 5'd9;
        #1;
        total++;
        if (pend_a !== 1'b1 || ra_data !== 32'h00000099) begin
            bad++; $display("FAIL set_wins got=%b/%h want=1/00000099", pend_a, ra_data);
        end
        we = 1'b1; w_adr = 5'd9; w_data = 32'h00000099;
        tick();
        we = 1'b0;
        #1;
        total++;
        if (pend_a !== 1'b0) begin
            bad++; $display("FAIL wb_after_set got=%b want=0", pend_a);
        end
    endtask

    task automatic test_soft_clear();
        int n;
        for (int i = 1; i < DEPTH; i++) begin
            we = 1'b1; w_adr = AW'(i); w_data = 32'h100 + i;
            tick();
        end
        we = 1'b0;
        ra_adr = 5'd3; rb_adr = 5'd31;
        #1;
        total++;
        if (ra_data !== 32'h103 || rb_data !== 32'h11f) begin
            bad++; $display("FAIL fill got=%h/%h want=00000103/0000011f", ra_data, rb_data);
        end
        iss_valid = 1'b1; iss_adr = 5'd12;
        tick();
        clr_req = 1'b1; we = 1'b1; w_adr = 5'd3; w_data = 32'h0000CAFE; iss_adr = 5'd10;
        tick();
        clr_req = 1'b0;
        #1;
        total++;
        if (ra_data !== '0 || pend_a !== 1'b0) begin
            bad++; $display("FAIL clr_busy_read got=%h/%b want=0/0", ra_data, pend_a);
        end
        count_busy(n);
        we = 1'b0; iss_valid = 1'b0;
        total++;
        if (n != 32) begin
            bad++; $display("FAIL clr_len got=%0d want=32", n);
        end
        for (int i = 0; i < DEPTH; i++) begin
            ra_adr = AW'(i);
            rb_adr = AW'(i);
            #1;
            total++;
            if (ra_data !== '0 || rb_data !== '0 || pend_a !== 1'b0 || pend_b !== 1'b0) begin
                bad++;
                $display("FAIL post_clr_zero adr=%0d got=%h/%h/%b/%b want=0", i,
                         ra_data, rb_data, pend_a, pend_b);
            end
        end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] exp_d;
        logic             exp_p;
        we = 1'b1; w_adr = 5'd4; w_data = 32'h11111111;
        iss_valid = 1'b1; iss_adr = 5'd4;
        tick();
        iss_valid = 1'b0;
        w_data = 32'hA5A5A5A5;
        ra_adr = 5'd4; rb_adr = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'hA5A5A5A5;
        exp_p = 1'b0;
`else
        exp_d = 32'h11111111;
        exp_p = 1'b1;
`endif
        total++;
        if (ra_data !== exp_d || rb_data !== exp_d || pend_a !== exp_p) begin
            bad++; $display("FAIL bypass_same_cycle got=%h/%h/%b want=%h/%b", ra_data, rb_data,
                            pend_a, exp_d, exp_p);
        end
        tick();
        we = 1'b0;
        #1;
        total++;
        if (ra_data !== 32'hA5A5A5A5 || pend_a !== 1'b0) begin
            bad++; $display("FAIL bypass_next got=%h/%b want=a5a5a5a5/0", ra_data, pend_a);
        end
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0; we = 1'b0; w_adr = '0; w_data = '0;
        ra_adr = '0; rb_adr = '0; iss_valid = 1'b0; iss_adr = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_scoreboard();
        test_set_wins();
        test_soft_clear();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
